// File: rtl/control_unit.sv
// control_unit: LEGv8 two-cycle FETCH/EXECUTE decoder driving a 64-bit control word and 32-bit immediate
//   clock, reset (sync, active-high); instruction[31:0] from instruction memory;
//   status[3:0] = {V,C,N,Z}; control_word[63:0]; constant[31:0].
//   Define CU_BCOND_EN to add ADDS/SUBS flag capture and B.cond.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  output logic [63:0] control_word,
  output logic [31:0] constant
);
  typedef enum logic {FETCH, EXECUTE} state_t;
  state_t state, state_n;
  logic [31:0] ir;
  logic [4:0] da, sa, sb, fs;
  logic rw, mw, bs, il, ex;
  logic [1:0] ds, ps;
  logic [31:0] k;
  assign state_n = (state == FETCH) ? EXECUTE : FETCH;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      ir <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH) ir <= instruction;
    end
  end
`ifdef CU_BCOND_EN
  logic [3:0] flags;
  logic set_flags, c_base, cond_ok;
  // Flags are captured only when an ADDS/SUBS retires, so B.cond sees the last flag-setting result.
  assign set_flags = (state == EXECUTE) && (ir[31:21] == 11'b10101011000 || ir[31:21] == 11'b11101011000);
  always_ff @(posedge clock) begin
    if (reset) flags <= '0;
    else if (set_flags) flags <= status;
  end
  // cond[3:1] picks the base test, cond[0] inverts it; 111x is always.
  always_comb begin
    c_base = (ir[3:1] == 3'd0) ? flags[0] :
             (ir[3:1] == 3'd1) ? flags[2] :
             (ir[3:1] == 3'd2) ? flags[1] :
             (ir[3:1] == 3'd3) ? flags[3] :
             (ir[3:1] == 3'd4) ? (flags[2] & ~flags[0]) :
             (ir[3:1] == 3'd5) ? (flags[1] == flags[3]) :
             (ir[3:1] == 3'd6) ? (~flags[0] & (flags[1] == flags[3])) : 1'b1;
    cond_ok = (ir[3:1] == 3'd7) ? 1'b1 : (c_base ^ ir[0]);
  end
`else
  logic unused_status;
  assign unused_status = ^status[3:1];
`endif
  always_comb begin
    da = '0;
    sa = '0;
    sb = '0;
    fs = '0;
    rw = 1'b0;
    mw = 1'b0;
    bs = 1'b0;
    ds = 2'b00;
    il = 1'b0;
    ps = 2'b00;
    ex = 1'b0;
    k = '0;
    if (!reset && state == FETCH) begin
      il = 1'b1;
      ps = 2'b01;
    end else if (!reset) begin
      ex = 1'b1;
      casez (ir[31:21])
`ifdef CU_BCOND_EN
        11'b10101011000, 11'b11101011000,
`endif
        11'b10001011000, 11'b11001011000: begin
          da = ir[4:0];
          sa = ir[9:5];
          sb = ir[20:16];
          fs = {4'd0, ir[30]};
          rw = 1'b1;
        end
        11'b10001010000, 11'b10101010000: begin
          da = ir[4:0];
          sa = ir[9:5];
          sb = ir[20:16];
          fs = ir[29] ? 5'd3 : 5'd2;
          rw = 1'b1;
        end
        11'b1001000100?, 11'b1101000100?: begin
          da = ir[4:0];
          sa = ir[9:5];
          fs = {4'd0, ir[30]};
          bs = 1'b1;
          rw = 1'b1;
          k = {20'd0, ir[21:10]};
        end
        11'b11111000010: begin
          da = ir[4:0];
          sa = ir[9:5];
          bs = 1'b1;
          ds = 2'b01;
          rw = 1'b1;
          k = {{23{ir[20]}}, ir[20:12]};
        end
        11'b11111000000: begin
          sa = ir[9:5];
          sb = ir[4:0];
          bs = 1'b1;
          mw = 1'b1;
          k = {{23{ir[20]}}, ir[20:12]};
        end
        11'b000101?????: begin
          ps = 2'b10;
          k = {{6{ir[25]}}, ir[25:0]};
        end
        // CBZ and CBNZ differ only in ir[24], which flips the sense of Z.
        11'b1011010????: begin
          sb = ir[4:0];
          fs = 5'd5;
          ps = (status[0] ^ ir[24]) ? 2'b10 : 2'b00;
          k = {{13{ir[23]}}, ir[23:5]};
        end
`ifdef CU_BCOND_EN
        11'b01010100???: begin
          ps = cond_ok ? 2'b10 : 2'b00;
          k = {{13{ir[23]}}, ir[23:5]};
        end
`endif
        default: ;
      endcase
    end
  end
  assign control_word = {35'd0, ex, ps, il, ds, bs, mw, rw, fs, sb, sa, da};
  assign constant = k;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit
module tb_control_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [3:0] status = '0;
  logic [63:0] control_word;
  logic [31:0] constant;
  int tests = 0;
  int fails = 0;
  logic [95:0] sb_q[$];
  control_unit dut (
    .clock(clock),
    .reset(reset),
    .instruction(instruction),
    .status(status),
    .control_word(control_word),
    .constant(constant)
  );
  always #5 clock = ~clock;
  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task run(input string tag, input logic [31:0] ins, input logic [3:0] st, input logic [63:0] ecw, input logic [31:0] ek);
    logic [95:0] e;
    instruction = ins;
    status = st;
    @(negedge clock);
    chk({tag, "_fetch_cw"}, control_word, 64'h0600_0000);
    chk({tag, "_fetch_k"}, {32'd0, constant}, 64'd0);
    sb_q.push_back({ecw, ek});
    @(posedge clock);
    #1 instruction = $urandom;
    @(negedge clock);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    else begin
      e = sb_q.pop_front();
      chk({tag, "_exec_cw"}, control_word, e[95:32]);
      chk({tag, "_exec_k"}, {32'd0, constant}, {32'd0, e[31:0]});
    end
    @(posedge clock);
    #1;
  endtask
  initial begin
    instruction = 32'h910193E4;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_cw", control_word, 64'd0);
    chk("reset_k", {32'd0, constant}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    run("addi_x4", 32'h910193E4, 4'h0, 64'h1050_03E4, 32'h64);
    run("addi_x8", 32'h91002108, 4'h0, 64'h1050_0108, 32'h8);
    run("addi_x9", 32'h91002129, 4'h0, 64'h1050_0129, 32'h8);
    run("ldur", 32'hF85F8041, 4'h0, 64'h10D0_0041, 32'hFFFF_FFF8);
    run("stur", 32'hF81F8041, 4'h0, 64'h1060_0440, 32'hFFFF_FFF8);
    run("cbz_taken", 32'hB4000083, 4'h1, 64'h1802_8C00, 32'h4);
    run("cbz_not", 32'hB4000083, 4'h0, 64'h1002_8C00, 32'h4);
    run("cbnz_taken", 32'hB5000083, 4'h0, 64'h1802_8C00, 32'h4);
    run("add", 32'h8B030041, 4'h0, 64'h1010_0C41, 32'h0);
    run("sub", 32'hCB030041, 4'h0, 64'h1010_8C41, 32'h0);
    run("and", 32'h8A030041, 4'h0, 64'h1011_0C41, 32'h0);
    run("orr", 32'hAA030041, 4'h0, 64'h1011_8C41, 32'h0);
    run("subi", 32'hD1000C21, 4'h0, 64'h1050_8021, 32'h3);
    run("b_back", 32'h17FFFFFE, 4'h0, 64'h1800_0000, 32'hFFFF_FFFE);
    run("nop", 32'h00000000, 4'hF, 64'h1000_0000, 32'h0);
`ifdef CU_BCOND_EN
    run("subs", 32'hEB010021, 4'h1, 64'h1010_8421, 32'h0);
    run("b_eq", 32'h54000080, 4'h0, 64'h1800_0000, 32'h4);
    run("b_ne", 32'h54000081, 4'h0, 64'h1000_0000, 32'h4);
    run("adds", 32'hAB010021, 4'h0, 64'h1010_0421, 32'h0);
    run("b_eq_clr", 32'h54000080, 4'h1, 64'h1000_0000, 32'h4);
    run("b_al", 32'h5400008E, 4'h0, 64'h1800_0000, 32'h4);
`else
    run("subs_nop", 32'hEB010021, 4'h1, 64'h1000_0000, 32'h0);
    run("bcond_nop", 32'h54000080, 4'h0, 64'h1000_0000, 32'h0);
`endif
    instruction = 32'hF81F8041;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midexec_reset_cw", control_word, 64'd0);
    chk("midexec_reset_k", {32'd0, constant}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    run("post_reset_addi", 32'h910193E4, 4'h0, 64'h1050_03E4, 32'h64);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
